// File: rtl/ser_frame_tx.sv
// Serial frame transmitter: sends {hdr, d, n} MSB first to a shift-register receiver.
// Optional build macro SER_TX_PARITY_EN puts even parity of {d, n} in frame[6].
module ser_frame_tx #(
  parameter logic [1:0] HDR      = 2'b10,
  parameter int         INIT_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] n_in,
  input  logic [1:0] d_in,
  output logic       ser_out,
  output logic       ser_en,
  output logic       ser_init,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] ILAST = 2'(INIT_CYC - 1);

  state_t     state, state_n;
  logic [7:0] sreg, sreg_n;
  logic [2:0] cnt, cnt_n;
  logic [1:0] icnt, icnt_n;
  logic [7:0] frame;

  // Frame image latched on acceptance
  always_comb begin
`ifdef SER_TX_PARITY_EN
    frame = {HDR[1], ^{d_in, n_in}, d_in, n_in};
`else
    frame = {HDR, d_in, n_in};
`endif
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      icnt  <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
      icnt  <= icnt_n;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    icnt_n  = icnt;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          sreg_n  = frame;
          cnt_n   = '0;
          icnt_n  = '0;
          state_n = INIT;
        end
      end
      INIT: begin
        if (icnt == ILAST) begin
          icnt_n  = '0;
          state_n = SHIFT;
        end else begin
          icnt_n = icnt + 2'd1;
        end
      end
      SHIFT: begin
        sreg_n = {sreg[6:0], 1'b0};
        cnt_n  = cnt + 3'd1;
        if (cnt == 3'd7) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs decode from registered state only
  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign ser_en   = (state == SHIFT);
  assign ser_init = (state == INIT);
  assign ser_out  = ser_en & sreg[7];
  assign done     = (state == DONE);

endmodule

// File: tb/tb_ser_frame_tx.sv
// Bench for ser_frame_tx: directed and random frames against a frame-level model.
// Two instances: default INIT_CYC and INIT_CYC=3.
module tb_ser_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv, iv3;
  logic [3:0] n;
  logic [1:0] d;
  logic       rdy, so, en, ini, bsy, dn;
  logic       rdy3, so3, en3, ini3, bsy3, dn3;
  logic [7:0] rx;
  int         cyc = 0;
  int         nchk = 0;
  int         nfail = 0;

  ser_frame_tx u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (iv),
    .in_ready (rdy),
    .n_in     (n),
    .d_in     (d),
    .ser_out  (so),
    .ser_en   (en),
    .ser_init (ini),
    .busy     (bsy),
    .done     (dn)
  );

  ser_frame_tx #(.INIT_CYC(3)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (iv3),
    .in_ready (rdy3),
    .n_in     (n),
    .d_in     (d),
    .ser_out  (so3),
    .ser_en   (en3),
    .ser_init (ini3),
    .busy     (bsy3),
    .done     (dn3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver: cleared by init strobe, shifts serial data in when enabled
  always @(posedge clk) begin
    if (rst)      rx <= '0;
    else if (ini) rx <= '0;
    else if (en)  rx <= {rx[6:0], so};
  end

  function automatic logic [7:0] frame_of(input logic [3:0] nn,
                                          input logic [1:0] dd);
    logic [1:0] h;
    h = 2'b10;
`ifdef SER_TX_PARITY_EN
    h[0] = ^{dd, nn};
`endif
    return {h, dd, nn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    nchk++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: got %0h, expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_rdy"}, 32'(rdy), 1);
    chk({tag, "_busy"}, 32'(bsy), 0);
    chk({tag, "_en"}, 32'(en), 0);
    chk({tag, "_init"}, 32'(ini), 0);
    chk({tag, "_out"}, 32'(so), 0);
    chk({tag, "_done"}, 32'(dn), 0);
  endtask

  task automatic wait_rdy(input string tag);
    int k;
    k = 0;
    while (!rdy && k < 50) begin
      tick();
      k++;
    end
    chk({tag, "_tmo"}, 32'(k < 50), 1);
  endtask

  // Send one frame on the default instance and check every cycle
  task automatic send(input logic [3:0] nn, input logic [1:0] dd,
                      input bit hold, output logic [7:0] got,
                      output int acc);
    logic [7:0] exp;
    exp = frame_of(nn, dd);
    got = '0;
    n   = nn;
    d   = dd;
    iv  = 1'b1;
    wait_rdy("acc");
    tick();
    acc = cyc;
    if (!hold) begin
      iv = 1'b0;
      n  = 4'($urandom);
      d  = 2'($urandom);
    end
    chk("init_hi", 32'(ini), 1);
    chk("init_en", 32'(en), 0);
    chk("init_out", 32'(so), 0);
    chk("init_busy", 32'(bsy), 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("sh_en", 32'(en), 1);
      chk("sh_init", 32'(ini), 0);
      chk("sh_bit", 32'(so), 32'(exp[7-i]));
      got = {got[6:0], so};
      tick();
    end
    chk("done", 32'(dn), 1);
    chk("done_en", 32'(en), 0);
    chk("done_out", 32'(so), 0);
    chk("rx_n", 32'(rx[3:0]), 32'(nn));
    chk("rx_d", 32'(rx[5:4]), 32'(dd));
    chk("rx_hdr", 32'(rx[7:6]), 32'(exp[7:6]));
    tick();
    chk("back_idle", 32'(rdy), 1);
    chk("done_pulse", 32'(dn), 0);
  endtask

  initial begin
    logic [7:0] got, exp3;
    int         a1, a2;
    logic [3:0] rn;
    logic [1:0] rd;

    rst = 1'b1;
    iv  = 1'b0;
    iv3 = 1'b0;
    n   = '0;
    d   = '0;

    // 1: reset
    repeat (3) tick();
    rst = 1'b0;
    check_idle("rst");
    chk("rst3_rdy", 32'(rdy3), 1);
    chk("rst3_init", 32'(ini3), 0);

    // 2: basic frame
    send(4'hA, 2'b01, 1'b0, got, a1);
`ifdef SER_TX_PARITY_EN
    chk("t6_a", 32'(got), 32'h DA);
`else
    chk("t2_bits", 32'(got), 32'h 9A);
`endif

    // 3: valid held high across two frames
    send(4'h3, 2'b10, 1'b1, got, a1);
    send(4'hC, 2'b11, 1'b0, got, a2);
    chk("t3_gap", 32'(a2 - a1), 11);

    // 4: reset mid-SHIFT after 4 shift edges
    n  = 4'h9;
    d  = 2'b11;
    iv = 1'b1;
    wait_rdy("t4");
    tick();
    iv = 1'b0;
    tick();
    repeat (4) tick();
    chk("t4_mid_en", 32'(en), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("t4");
    send(4'h5, 2'b00, 1'b0, got, a1);
    chk("t4_bits", 32'(got), 32'h 85);

    // 5: INIT_CYC=3 instance
    rn   = 4'($urandom);
    rd   = 2'($urandom);
    exp3 = frame_of(rn, rd);
    n    = rn;
    d    = rd;
    iv3  = 1'b1;
    chk("t5_rdy", 32'(rdy3), 1);
    tick();
    iv3 = 1'b0;
    n   = ~rn;
    for (int i = 0; i < 3; i++) begin
      chk("t5_init", 32'(ini3), 1);
      chk("t5_en", 32'(en3), 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      chk("t5_sh_init", 32'(ini3), 0);
      chk("t5_sh_en", 32'(en3), 1);
      chk("t5_bit", 32'(so3), 32'(exp3[7-i]));
      tick();
    end
    chk("t5_done", 32'(dn3), 1);
    tick();
    chk("t5_idle", 32'(rdy3), 1);

`ifdef SER_TX_PARITY_EN
    // 6: parity build, zero-parity case
    send(4'h3, 2'b00, 1'b0, got, a1);
    chk("t6_b", 32'(got), 32'h 83);
`endif

    // Random frames
    for (int k = 0; k < 8; k++) begin
      rn = 4'($urandom);
      rd = 2'($urandom);
      send(rn, rd, 1'b0, got, a1);
      chk("rnd_frame", 32'(got), 32'(frame_of(rn, rd)));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
